// File: rtl/rv32i_fetch_ctrl_if.sv
// Fetch-control bus: branch resolution, hazard stall, program loader and instruction-memory port.
// master = fetch controller, slave = surrounding pipeline, loader and memory.
interface rv32i_fetch_ctrl_if;
    logic [31:0] PCIMM_IN;
    logic        CTRL_PCSRC_IN;
    logic        STALL_IN;
    logic        LOAD_REQ_IN;
    logic [31:0] LOAD_ADDR_IN;
    logic [31:0] LOAD_DATA_IN;
    logic        LOAD_WE_IN;
    logic        LOAD_GNT_OUT;
    logic [31:0] IMEM_ADDR_OUT;
    logic        IMEM_WE_OUT;
    logic [31:0] IMEM_WDATA_OUT;
    logic [31:0] PC_OUT;
    logic        IF_VALID_OUT;
    logic        FLUSH_OUT;
    logic        MISALIGN_OUT;

    modport master (
        input  PCIMM_IN, CTRL_PCSRC_IN, STALL_IN,
        input  LOAD_REQ_IN, LOAD_ADDR_IN, LOAD_DATA_IN, LOAD_WE_IN,
        output LOAD_GNT_OUT, IMEM_ADDR_OUT, IMEM_WE_OUT, IMEM_WDATA_OUT,
        output PC_OUT, IF_VALID_OUT, FLUSH_OUT, MISALIGN_OUT
    );

    modport slave (
        output PCIMM_IN, CTRL_PCSRC_IN, STALL_IN,
        output LOAD_REQ_IN, LOAD_ADDR_IN, LOAD_DATA_IN, LOAD_WE_IN,
        input  LOAD_GNT_OUT, IMEM_ADDR_OUT, IMEM_WE_OUT, IMEM_WDATA_OUT,
        input  PC_OUT, IF_VALID_OUT, FLUSH_OUT, MISALIGN_OUT
    );
endinterface

// File: rtl/rv32i_fetch_ctrl.sv
// RV32I fetch sequencer: PC register, stall/redirect/flush handling and imem port arbitration with a loader.
// Optional macro RV32I_FETCH_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VEC and pulses MISALIGN_OUT.
module rv32i_fetch_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC      = 32'h0000_0100,
    parameter int unsigned FLUSH_BUBBLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32i_fetch_ctrl_if.master    bus
);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN, LOAD} state_e;

    localparam bit         HAS_DRAIN = (FLUSH_BUBBLES > 0);
    localparam logic [1:0] BUB_INIT  = HAS_DRAIN ? 2'(FLUSH_BUBBLES - 1) : 2'd0;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  bub_q, bub_d;

    logic        valid_c, flush_c, misalign_c, gnt_c;
    logic [31:0] redir_pc;
    logic        redir_misaligned;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    assign redir_misaligned = (bus.PCIMM_IN[1:0] != 2'b00);
    assign redir_pc         = redir_misaligned ? TRAP_VEC : bus.PCIMM_IN;
`else
    assign redir_misaligned = 1'b0;
    assign redir_pc         = {bus.PCIMM_IN[31:2], 2'b00};
    logic unused_trap;
    assign unused_trap = ^{TRAP_VEC, bus.PCIMM_IN[1:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            bub_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= {pc_d[31:2], 2'b00};
            bub_q   <= bub_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bub_d      = bub_q;
        valid_c    = 1'b0;
        flush_c    = 1'b0;
        misalign_c = 1'b0;
        gnt_c      = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = bus.LOAD_REQ_IN ? LOAD : RUN;
            end
            RUN: begin
                valid_c = 1'b1;
                // A redirect wins over a stall; the PC update completes even when the loader takes over.
                if (bus.CTRL_PCSRC_IN) begin
                    pc_d       = redir_pc;
                    flush_c    = 1'b1;
                    misalign_c = redir_misaligned;
                    if (HAS_DRAIN) begin
                        state_d = DRAIN;
                        bub_d   = BUB_INIT;
                    end
                end else if (!bus.STALL_IN) begin
                    pc_d = pc_q + 32'd4;
                end
                if (bus.LOAD_REQ_IN) begin
                    state_d = LOAD;
                    bub_d   = 2'd0;
                end
            end
            DRAIN: begin
                if (bus.LOAD_REQ_IN) begin
                    state_d = LOAD;
                    bub_d   = 2'd0;
                end else if (bub_q == 2'd0) begin
                    state_d = RUN;
                end else begin
                    bub_d = bub_q - 2'd1;
                end
            end
            LOAD: begin
                gnt_c = 1'b1;
                if (!bus.LOAD_REQ_IN) begin
                    state_d = BOOT;
                    pc_d    = RESET_PC;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_PC;
            end
        endcase
    end

    assign bus.LOAD_GNT_OUT   = gnt_c;
    assign bus.IMEM_ADDR_OUT  = gnt_c ? bus.LOAD_ADDR_IN : pc_q;
    assign bus.IMEM_WE_OUT    = gnt_c & bus.LOAD_WE_IN;
    assign bus.IMEM_WDATA_OUT = bus.LOAD_DATA_IN;
    assign bus.PC_OUT         = pc_q;
    assign bus.IF_VALID_OUT   = valid_c;
    assign bus.FLUSH_OUT      = flush_c;
    assign bus.MISALIGN_OUT   = misalign_c;

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Directed bench for rv32i_fetch_ctrl with FLUSH_BUBBLES = 2 and a small word-addressed imem model.
module tb_rv32i_fetch_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    rv32i_fetch_ctrl_if bus ();

    rv32i_fetch_ctrl #(
        .RESET_PC      (32'h0000_0000),
        .TRAP_VEC      (32'h0000_0100),
        .FLUSH_BUBBLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [31:0] mem [0:63];
    logic [31:0] imem_rdata;
    assign imem_rdata = mem[bus.IMEM_ADDR_OUT[7:2]];
    always @(posedge clk) if (bus.IMEM_WE_OUT) mem[bus.IMEM_ADDR_OUT[7:2]] <= bus.IMEM_WDATA_OUT;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_PC  = 32'h0000_0100;
    localparam logic        MIS_BIT = 1'b1;
`else
    localparam logic [31:0] MIS_PC  = 32'h0000_0040;
    localparam logic        MIS_BIT = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.PCIMM_IN = 32'h0; bus.CTRL_PCSRC_IN = 1'b0; bus.STALL_IN = 1'b0;
        bus.LOAD_REQ_IN = 1'b0; bus.LOAD_ADDR_IN = 32'h0; bus.LOAD_DATA_IN = 32'h0; bus.LOAD_WE_IN = 1'b0;
        #3;
        n_vec++; if (bus.PC_OUT !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.PC_OUT, 32'h0); end
        n_vec++; if (bus.IF_VALID_OUT !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.IF_VALID_OUT); end
        n_vec++; if (bus.LOAD_GNT_OUT !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", bus.LOAD_GNT_OUT); end
        n_vec++; if (bus.FLUSH_OUT !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", bus.FLUSH_OUT); end
        n_vec++; if (bus.MISALIGN_OUT !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", bus.MISALIGN_OUT); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (bus.IF_VALID_OUT !== 1'b0) begin n_err++; $display("FAIL boot_valid: got %b want 0", bus.IF_VALID_OUT); end
        n_vec++; if (bus.PC_OUT !== 32'h0) begin n_err++; $display("FAIL boot_pc: got %h want %h", bus.PC_OUT, 32'h0); end
        $display("reset: boot cycle pc=%h valid=%b", bus.PC_OUT, bus.IF_VALID_OUT);
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.PC_OUT !== 32'(4 * i)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.PC_OUT, 32'(4 * i)); end
            n_vec++; if (bus.IF_VALID_OUT !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", i, bus.IF_VALID_OUT); end
            $display("seq: pc=%h valid=%b", bus.PC_OUT, bus.IF_VALID_OUT);
        end
    endtask

    task automatic test_stall();
        bus.STALL_IN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (bus.PC_OUT !== 32'h8) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want %h", k, bus.PC_OUT, 32'h8); end
            n_vec++; if (bus.IF_VALID_OUT !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", k, bus.IF_VALID_OUT); end
            n_vec++; if (bus.FLUSH_OUT !== 1'b0) begin n_err++; $display("FAIL stall_flush[%0d]: got %b want 0", k, bus.FLUSH_OUT); end
            $display("stall: pc=%h valid=%b", bus.PC_OUT, bus.IF_VALID_OUT);
            tick();
        end
        bus.STALL_IN = 1'b0;
        #1;
        n_vec++; if (bus.PC_OUT !== 32'h8) begin n_err++; $display("FAIL stall_hold: got %h want %h", bus.PC_OUT, 32'h8); end
        tick();
        n_vec++; if (bus.PC_OUT !== 32'hC) begin n_err++; $display("FAIL stall_resume: got %h want %h", bus.PC_OUT, 32'hC); end
        $display("stall release: pc=%h", bus.PC_OUT);
        tick();
    endtask

    task automatic test_redirect();
        n_vec++; if (bus.PC_OUT !== 32'h10) begin n_err++; $display("FAIL redir_start_pc: got %h want %h", bus.PC_OUT, 32'h10); end
        bus.CTRL_PCSRC_IN = 1'b1; bus.STALL_IN = 1'b1; bus.PCIMM_IN = 32'h40;
        #1;
        n_vec++; if (bus.FLUSH_OUT !== 1'b1) begin n_err++; $display("FAIL redir_flush: got %b want 1", bus.FLUSH_OUT); end
        tick();
        bus.CTRL_PCSRC_IN = 1'b0; bus.STALL_IN = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++; if (bus.PC_OUT !== 32'h40) begin n_err++; $display("FAIL drain_pc[%0d]: got %h want %h", k, bus.PC_OUT, 32'h40); end
            n_vec++; if (bus.IF_VALID_OUT !== 1'b0) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 0", k, bus.IF_VALID_OUT); end
            n_vec++; if (bus.FLUSH_OUT !== 1'b0) begin n_err++; $display("FAIL drain_flush[%0d]: got %b want 0", k, bus.FLUSH_OUT); end
            $display("drain: pc=%h valid=%b", bus.PC_OUT, bus.IF_VALID_OUT);
            tick();
        end
        n_vec++; if (bus.PC_OUT !== 32'h40 || bus.IF_VALID_OUT !== 1'b1) begin n_err++; $display("FAIL redir_first: got %h/%b want %h/1", bus.PC_OUT, bus.IF_VALID_OUT, 32'h40); end
        tick();
        n_vec++; if (bus.PC_OUT !== 32'h44 || bus.IF_VALID_OUT !== 1'b1) begin n_err++; $display("FAIL redir_next: got %h/%b want %h/1", bus.PC_OUT, bus.IF_VALID_OUT, 32'h44); end
        $display("redirect: pc=%h valid=%b", bus.PC_OUT, bus.IF_VALID_OUT);
    endtask

    task automatic test_wrap();
        bus.CTRL_PCSRC_IN = 1'b1; bus.PCIMM_IN = 32'hFFFF_FFFC;
        tick();
        bus.CTRL_PCSRC_IN = 1'b0;
        tick();
        tick();
        n_vec++; if (bus.PC_OUT !== 32'hFFFF_FFFC || bus.IF_VALID_OUT !== 1'b1) begin n_err++; $display("FAIL wrap_top: got %h/%b want %h/1", bus.PC_OUT, bus.IF_VALID_OUT, 32'hFFFF_FFFC); end
        tick();
        n_vec++; if (bus.PC_OUT !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h want %h", bus.PC_OUT, 32'h0); end
        $display("wrap: pc=%h", bus.PC_OUT);
    endtask

    task automatic test_misalign();
        bus.CTRL_PCSRC_IN = 1'b1; bus.PCIMM_IN = 32'h42;
        #1;
        n_vec++; if (bus.MISALIGN_OUT !== MIS_BIT) begin n_err++; $display("FAIL mis_pulse: got %b want %b", bus.MISALIGN_OUT, MIS_BIT); end
        n_vec++; if (bus.FLUSH_OUT !== 1'b1) begin n_err++; $display("FAIL mis_flush: got %b want 1", bus.FLUSH_OUT); end
        tick();
        bus.CTRL_PCSRC_IN = 1'b0;
        #1;
        n_vec++; if (bus.PC_OUT !== MIS_PC) begin n_err++; $display("FAIL mis_pc: got %h want %h", bus.PC_OUT, MIS_PC); end
        n_vec++; if (bus.MISALIGN_OUT !== 1'b0) begin n_err++; $display("FAIL mis_once: got %b want 0", bus.MISALIGN_OUT); end
        tick();
        tick();
        n_vec++; if (bus.PC_OUT !== MIS_PC || bus.IF_VALID_OUT !== 1'b1) begin n_err++; $display("FAIL mis_run: got %h/%b want %h/1", bus.PC_OUT, bus.IF_VALID_OUT, MIS_PC); end
        $display("misalign redirect: pc=%h", bus.PC_OUT);
    endtask

    task automatic test_loader();
        bus.LOAD_REQ_IN = 1'b1; bus.LOAD_WE_IN = 1'b1; bus.LOAD_ADDR_IN = 32'h10; bus.LOAD_DATA_IN = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (bus.LOAD_GNT_OUT !== 1'b0) begin n_err++; $display("FAIL load_pre_gnt: got %b want 0", bus.LOAD_GNT_OUT); end
        n_vec++; if (bus.IMEM_WE_OUT !== 1'b0) begin n_err++; $display("FAIL load_pre_we: got %b want 0", bus.IMEM_WE_OUT); end
        tick();
        n_vec++; if (bus.LOAD_GNT_OUT !== 1'b1 || bus.IF_VALID_OUT !== 1'b0) begin n_err++; $display("FAIL load_gnt: got %b/%b want 1/0", bus.LOAD_GNT_OUT, bus.IF_VALID_OUT); end
        for (int i = 0; i < 4; i++) begin
            bus.LOAD_ADDR_IN = 32'(4 * i); bus.LOAD_DATA_IN = 32'hA0 + 32'(i); bus.LOAD_WE_IN = 1'b1;
            #1;
            n_vec++; if (bus.IMEM_WE_OUT !== 1'b1 || bus.IMEM_ADDR_OUT !== 32'(4 * i) || bus.IMEM_WDATA_OUT !== 32'hA0 + 32'(i))
                begin n_err++; $display("FAIL load_wr[%0d]: got we=%b a=%h d=%h want we=1 a=%h d=%h", i, bus.IMEM_WE_OUT, bus.IMEM_ADDR_OUT, bus.IMEM_WDATA_OUT, 32'(4 * i), 32'hA0 + 32'(i)); end
            $display("load write: addr=%h data=%h we=%b", bus.IMEM_ADDR_OUT, bus.IMEM_WDATA_OUT, bus.IMEM_WE_OUT);
            tick();
        end
        bus.LOAD_WE_IN = 1'b0;
        #1;
        n_vec++; if (bus.IMEM_WE_OUT !== 1'b0) begin n_err++; $display("FAIL load_we_follow: got %b want 0", bus.IMEM_WE_OUT); end
        bus.LOAD_REQ_IN = 1'b0;
        #1;
        n_vec++; if (bus.LOAD_GNT_OUT !== 1'b1) begin n_err++; $display("FAIL load_gnt_hold: got %b want 1", bus.LOAD_GNT_OUT); end
        tick();
        n_vec++; if (bus.LOAD_GNT_OUT !== 1'b0 || bus.IF_VALID_OUT !== 1'b0 || bus.PC_OUT !== 32'h0)
            begin n_err++; $display("FAIL load_boot: got gnt=%b v=%b pc=%h want 0/0/%h", bus.LOAD_GNT_OUT, bus.IF_VALID_OUT, bus.PC_OUT, 32'h0); end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (bus.PC_OUT !== 32'(4 * i) || bus.IF_VALID_OUT !== 1'b1) begin n_err++; $display("FAIL fetch_pc[%0d]: got %h/%b want %h/1", i, bus.PC_OUT, bus.IF_VALID_OUT, 32'(4 * i)); end
            if (i < 4) begin
                n_vec++; if (imem_rdata !== 32'hA0 + 32'(i)) begin n_err++; $display("FAIL fetch_data[%0d]: got %h want %h", i, imem_rdata, 32'hA0 + 32'(i)); end
            end else begin
                n_vec++; if (imem_rdata === 32'hDEAD_BEEF) begin n_err++; $display("FAIL pregrant_write: got %h want not %h", imem_rdata, 32'hDEAD_BEEF); end
            end
            $display("fetch: pc=%h data=%h", bus.PC_OUT, imem_rdata);
            tick();
        end
    endtask

    task automatic test_reset_mid_load();
        bus.LOAD_REQ_IN = 1'b1;
        tick();
        bus.LOAD_WE_IN = 1'b1; bus.LOAD_ADDR_IN = 32'h20; bus.LOAD_DATA_IN = 32'h5;
        #1;
        n_vec++; if (bus.IMEM_WE_OUT !== 1'b1 || bus.LOAD_GNT_OUT !== 1'b1) begin n_err++; $display("FAIL midload_we: got %b/%b want 1/1", bus.IMEM_WE_OUT, bus.LOAD_GNT_OUT); end
        rst = 1'b1;
        #1;
        n_vec++; if (bus.IMEM_WE_OUT !== 1'b0 || bus.LOAD_GNT_OUT !== 1'b0) begin n_err++; $display("FAIL midload_abort: got we=%b gnt=%b want 0/0", bus.IMEM_WE_OUT, bus.LOAD_GNT_OUT); end
        n_vec++; if (bus.PC_OUT !== 32'h0 || bus.IF_VALID_OUT !== 1'b0) begin n_err++; $display("FAIL midload_pc: got %h/%b want %h/0", bus.PC_OUT, bus.IF_VALID_OUT, 32'h0); end
        $display("reset mid-load: we=%b gnt=%b pc=%h", bus.IMEM_WE_OUT, bus.LOAD_GNT_OUT, bus.PC_OUT);
        bus.LOAD_REQ_IN = 1'b0; bus.LOAD_WE_IN = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if (bus.IF_VALID_OUT !== 1'b0) begin n_err++; $display("FAIL midload_boot: got %b want 0", bus.IF_VALID_OUT); end
        tick();
        n_vec++; if (bus.PC_OUT !== 32'h0 || bus.IF_VALID_OUT !== 1'b1) begin n_err++; $display("FAIL midload_restart: got %h/%b want %h/1", bus.PC_OUT, bus.IF_VALID_OUT, 32'h0); end
        $display("restart: pc=%h valid=%b", bus.PC_OUT, bus.IF_VALID_OUT);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_misalign();
        test_loader();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
